// File: rtl/game_ctrl_pkg.sv
// Shared types and helpers for the game round controller.
package game_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLIGHT = 2'd1,
      RESULT = 2'd2,
      OVER   = 2'd3
   } game_state_t;

   localparam int BCD_W = 4;

   function automatic logic [BCD_W-1:0] bcd_inc_sat(
      input logic [BCD_W-1:0] d
   );
      return (d >= BCD_W'(9)) ? BCD_W'(9) : d + BCD_W'(1);
   endfunction

endpackage

// File: rtl/game_key_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer.
module game_key_debounce #(
   parameter int debounce_cycles = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_raw,
   output logic key_db
);

   localparam int CW = $clog2(debounce_cycles + 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // Any sample matching the current level restarts the count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         key_db <= 1'b0;
         cnt    <= '0;
      end else begin
         sync1 <= key_raw;
         sync2 <= sync1;
         if (sync2 == key_db) begin
            cnt <= '0;
         end else if (cnt == CW'(debounce_cycles - 1)) begin
            key_db <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/game_round_controller.sv
// Round sequencer: key launch, outcome tracking, scores and game over.
module game_round_controller
   import game_ctrl_pkg::*;
#(
   parameter int clk_mhz               = 50,
   parameter int debounce_cycles       = clk_mhz * 1000,
   parameter int flight_timeout_cycles = clk_mhz * 5_000_000,
   parameter int result_hold_cycles    = clk_mhz * 1_000_000,
   parameter int max_misses            = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             key_left,
   input  logic             key_right,
   input  logic             hit,
   input  logic             miss,
   output logic             launch,
   output logic [1:0]       left_right,
   output logic [1:0]       state,
   output logic [BCD_W-1:0] hits,
   output logic [BCD_W-1:0] misses,
   output logic             game_over
);

   localparam int FT_W = $clog2(flight_timeout_cycles + 1);
   localparam int RH_W = $clog2(result_hold_cycles + 1);

   game_state_t      cur, nxt;
   logic             left_db, right_db;
   logic             db_prev, press;
   logic             launch_n;
   logic [BCD_W-1:0] hits_n, misses_n;
   logic [FT_W-1:0]  flight_cnt;
   logic [RH_W-1:0]  hold_cnt;
   logic             flight_done, hold_done;

   game_key_debounce #(.debounce_cycles(debounce_cycles)) u_db_left (
      .clk     (clk),
      .reset   (reset),
      .key_raw (key_left),
      .key_db  (left_db)
   );

   game_key_debounce #(.debounce_cycles(debounce_cycles)) u_db_right (
      .clk     (clk),
      .reset   (reset),
      .key_raw (key_right),
      .key_db  (right_db)
   );

   assign left_right = {left_db, right_db};
   assign state      = cur;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_prev <= 1'b0;
         press   <= 1'b0;
      end else begin
         db_prev <= left_db | right_db;
         press   <= (left_db | right_db) & ~db_prev;
      end
   end

   // Timers idle at zero outside their own state, so entry starts at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flight_cnt <= '0;
         hold_cnt   <= '0;
      end else begin
         flight_cnt <= (cur == FLIGHT) ? flight_cnt + FT_W'(1) : '0;
         hold_cnt   <= (cur == RESULT) ? hold_cnt + RH_W'(1) : '0;
      end
   end

   assign flight_done = (flight_cnt == FT_W'(flight_timeout_cycles - 1));
   assign hold_done   = (hold_cnt == RH_W'(result_hold_cycles - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur    <= IDLE;
         launch <= 1'b0;
         hits   <= '0;
         misses <= '0;
      end else begin
         cur    <= nxt;
         launch <= launch_n;
         hits   <= hits_n;
         misses <= misses_n;
      end
   end

   always_comb begin
      nxt      = cur;
      launch_n = 1'b0;
      hits_n   = hits;
      misses_n = misses;
      unique case (cur)
         IDLE: begin
            if (press) begin
               nxt      = FLIGHT;
               launch_n = 1'b1;
            end
         end
         FLIGHT: begin
            if (hit) begin
               hits_n = bcd_inc_sat(hits);
               nxt    = RESULT;
            end else if (miss || flight_done) begin
               misses_n = misses + BCD_W'(1);
               nxt      = RESULT;
            end
         end
         RESULT: begin
            if (hold_done)
               nxt = (misses == BCD_W'(max_misses)) ? OVER : IDLE;
         end
         OVER: begin
            if (press) begin
               hits_n   = '0;
               misses_n = '0;
               nxt      = IDLE;
            end
         end
      endcase
   end

   always_comb begin
      game_over = (cur == OVER);
   end

endmodule

// File: tb/tb_game_round_controller.sv
// Directed bench for game_round_controller with small timing parameters.
module tb_game_round_controller;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FLIGHT = 2'd1;
   localparam logic [1:0] S_RESULT = 2'd2;
   localparam logic [1:0] S_OVER   = 2'd3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       key_left = 1'b0;
   logic       key_right = 1'b0;
   logic       hit = 1'b0;
   logic       miss = 1'b0;
   logic       launch;
   logic [1:0] left_right;
   logic [1:0] state;
   logic [3:0] hits;
   logic [3:0] misses;
   logic       game_over;

   int vectors = 0;
   int errs = 0;
   logic saw_l;
   logic saw_lr;

   always #5 clk = ~clk;

   game_round_controller #(
      .debounce_cycles       (4),
      .flight_timeout_cycles (20),
      .result_hold_cycles    (8),
      .max_misses            (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .key_left   (key_left),
      .key_right  (key_right),
      .hit        (hit),
      .miss       (miss),
      .launch     (launch),
      .left_right (left_right),
      .state      (state),
      .hits       (hits),
      .misses     (misses),
      .game_over  (game_over)
   );

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic launch_round();
      logic seen;
      seen = 1'b0;
      key_left = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (launch) begin
            seen = 1'b1;
            break;
         end
      end
      chk("launch_seen", 32'(seen), 32'd1);
      chk("launch_state", 32'(state), 32'(S_FLIGHT));
      key_left = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, 32'(state), 32'(S_IDLE));
      chk({tag, "_launch"}, 32'(launch), 32'd0);
      chk({tag, "_lr"}, 32'(left_right), 32'd0);
      chk({tag, "_hits"}, 32'(hits), 32'd0);
      chk({tag, "_misses"}, 32'(misses), 32'd0);
      chk({tag, "_over"}, 32'(game_over), 32'd0);
   endtask

   initial begin
      tick(2);
      chk_reset_vals("rst");
      reset = 1'b0;
      tick();

      // Clean press on left key
      key_left = 1'b1;
      tick(5);
      chk("lr_before", 32'(left_right), 32'd0);
      tick();
      chk("lr_after6", 32'(left_right), 32'h2);
      tick();
      chk("launch_early", 32'(launch), 32'd0);
      chk("state_press", 32'(state), 32'(S_IDLE));
      tick();
      chk("launch_hi", 32'(launch), 32'd1);
      chk("state_flight", 32'(state), 32'(S_FLIGHT));
      tick();
      chk("launch_width", 32'(launch), 32'd0);
      tick();
      key_left = 1'b0;
      tick(2);

      // Hit and miss together in flight cycle 5
      hit = 1'b1;
      miss = 1'b1;
      tick();
      hit = 1'b0;
      miss = 1'b0;
      chk("hit_state", 32'(state), 32'(S_RESULT));
      chk("hit_hits", 32'(hits), 32'd1);
      chk("hit_misses", 32'(misses), 32'd0);
      hit = 1'b1;
      tick();
      hit = 1'b0;
      tick(6);
      chk("hold_7", 32'(state), 32'(S_RESULT));
      tick();
      chk("hold_done", 32'(state), 32'(S_IDLE));
      chk("hit_ignored", 32'(hits), 32'd1);

      // Bouncing right key
      saw_l = 1'b0;
      saw_lr = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) key_right = ~key_right;
         tick();
         if (launch) saw_l = 1'b1;
         if (left_right != 2'b00) saw_lr = 1'b1;
      end
      key_right = 1'b0;
      tick(10);
      chk("bounce_lr", 32'(saw_lr), 32'd0);
      chk("bounce_launch", 32'(saw_l), 32'd0);
      chk("bounce_state", 32'(state), 32'(S_IDLE));

      // First timeout
      launch_round();
      tick(18);
      chk("to1_c19", 32'(state), 32'(S_FLIGHT));
      tick();
      chk("to1_c20", 32'(state), 32'(S_FLIGHT));
      tick();
      chk("to1_state", 32'(state), 32'(S_RESULT));
      chk("to1_misses", 32'(misses), 32'd1);
      tick(7);
      chk("to1_hold", 32'(state), 32'(S_RESULT));
      tick();
      chk("to1_idle", 32'(state), 32'(S_IDLE));

      // Second timeout ends the game
      launch_round();
      tick(20);
      chk("to2_state", 32'(state), 32'(S_RESULT));
      chk("to2_misses", 32'(misses), 32'd2);
      tick(8);
      chk("over_state", 32'(state), 32'(S_OVER));
      chk("over_flag", 32'(game_over), 32'd1);
      chk("over_hits", 32'(hits), 32'd1);

      // Press in OVER clears scores without launching
      key_left = 1'b1;
      saw_l = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (launch) saw_l = 1'b1;
      end
      chk("clr_state", 32'(state), 32'(S_IDLE));
      chk("clr_hits", 32'(hits), 32'd0);
      chk("clr_misses", 32'(misses), 32'd0);
      chk("clr_over", 32'(game_over), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (launch) saw_l = 1'b1;
      end
      chk("clr_nolaunch", 32'(saw_l), 32'd0);
      key_left = 1'b0;
      tick(10);

      // Ten hits saturate at 9
      for (int r = 0; r < 10; r++) begin
         launch_round();
         hit = 1'b1;
         tick();
         hit = 1'b0;
         chk("sat_hits", 32'(hits), (r < 9) ? 32'(r + 1) : 32'd9);
         tick(8);
      end
      chk("sat_idle", 32'(state), 32'(S_IDLE));

      // Asynchronous reset mid-flight
      launch_round();
      tick(3);
      chk("pre_rst_hits", 32'(hits), 32'd9);
      chk("pre_rst_state", 32'(state), 32'(S_FLIGHT));
      reset = 1'b1;
      #1;
      chk_reset_vals("arst");
      tick(2);
      reset = 1'b0;
      tick();
      chk("post_rst", 32'(state), 32'(S_IDLE));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/game_round_controller.md
# game_round_controller

Round sequencer placed between the board keys and `game_top`. Debounces and synchronizes the left/right keys, turns a fresh press into a single-cycle `launch` strobe, then tracks the round outcome (hit, miss or timeout) reported back by the game core. It keeps hit/miss scores for the 7-segment display and ends the game after a programmable number of misses.

## Interface
- `clk_mhz`, 50, clock frequency in MHz; used only to derive the defaults below
- `debounce_cycles`, `clk_mhz*1000`, number of consecutive stable cycles needed to accept a key change (1 ms)
- `flight_timeout_cycles`, `clk_mhz*5_000_000`, maximum FLIGHT duration before a forced miss (5 s)
- `result_hold_cycles`, `clk_mhz*1_000_000`, dwell time in RESULT (1 s)
- `max_misses`, 3, miss count that ends the game; legal range 1..9

- `clk` input 1: the single clock
- `reset` input 1: asynchronous, active-high
- `key_left` input 1: raw left key, active-high, asynchronous to `clk`
- `key_right` input 1: raw right key, active-high, asynchronous to `clk`
- `hit` input 1: from game core, target hit, level or pulse
- `miss` input 1: from game core, sprite left screen, level or pulse
- `launch` output 1: one-cycle strobe to game core `launch_key`
- `left_right` output 2: debounced `{left, right}` levels to game core `left_right_keys`
- `state` output 2: current FSM state, encoded per package
- `hits` output 4: BCD hit count, 0..9
- `misses` output 4: BCD miss count, 0..`max_misses`
- `game_over` output 1: high while in OVER

## Operation
- Each key passes through a 2-FF synchronizer and then a debounce counter.
  - The debounced level changes only after the synchronized value has differed from it for `debounce_cycles` consecutive cycles.
  - Any bounce restarts the count.
- `press` is the rising edge of the debounced value of (`left` | `right`), one cycle wide.
- FSM states are IDLE, FLIGHT, RESULT and OVER.
  - **IDLE:** on `press`, go to FLIGHT, assert `launch`, clear the flight timer.
  - **FLIGHT:**
    - If `hit`: `hits` is incremented, saturating at 9, and the FSM goes to RESULT.
    - Else if `miss` or the timer reaches `flight_timeout_cycles`-1: `misses` is incremented and the FSM goes to RESULT.
    - `hit` and `miss` in the same cycle count as a hit.
  - **RESULT:** count `result_hold_cycles`, then go to OVER if `misses` == `max_misses`, else to IDLE.
  - **OVER:** `game_over`=1. On `press`, clear `hits` and `misses` and go to IDLE; no `launch` is issued.
- Presses in FLIGHT or RESULT are discarded, not queued.
- `hit`/`miss` outside FLIGHT are ignored.
- `left_right` is always the live debounced level, independent of FSM state.

## Timing
- Reset values:
  - `state`=IDLE, `launch`=0, `left_right`=2'b00, `hits`=0, `misses`=0, `game_over`=0.
  - Debounced levels = 0, all counters = 0.
- Key-to-`press` latency: 2 (sync) + `debounce_cycles` + 1 (edge register).
- `launch` is registered.
  - It is high in exactly the first cycle that `state`=FLIGHT, i.e. one cycle after `press`.
- `hit`/`miss` are sampled every FLIGHT cycle.
  - The transition and score update take effect on the next edge, with no further delay.
  - The first FLIGHT cycle, the one in which `launch` is high, also samples them.
- Timeout: if `hit`/`miss` never arrive, exactly `flight_timeout_cycles` cycles are spent in FLIGHT.
- RESULT lasts exactly `result_hold_cycles` cycles.
- Reset asserted mid-round:
  - All outputs return to their reset values immediately, asynchronously.
  - Any pending debounce count is lost.
- All counters use `$clog2(param+1)` widths.
  - No wrap-around is possible, because each counter is cleared on state entry.

## Structure
- Package `game_ctrl_pkg` holds:
  - the state enum `game_state_t` (IDLE=0, FLIGHT=1, RESULT=2, OVER=3);
  - the BCD digit width constant;
  - a helper function for the saturating BCD increment.
- Sub-module `game_key_debounce` (parameter `debounce_cycles`; ports `clk`, `reset`, `key_raw`, `key_db`) contains the synchronizer and the debounce counter.
  - It is instantiated twice.
- Edge detect, FSM, timers and score registers live in `game_round_controller`.

## Test plan
Run with `debounce_cycles`=4, `flight_timeout_cycles`=20, `result_hold_cycles`=8, `max_misses`=2.
- **Clean press:** after reset, hold `key_left` high for 10 cycles.
  - `left_right`=2'b10 after 6 cycles.
  - `launch` is high for exactly 1 cycle, 1 cycle after `press`.
  - `state`=FLIGHT.
- **Bounce:** toggle `key_right` every 2 cycles for 20 cycles, then release.
  - `left_right` stays 2'b00; no `launch`.
- **Hit path:** launch, then pulse `hit` together with `miss` in FLIGHT cycle 5.
  - `hits`=1, `misses`=0, RESULT for 8 cycles, then IDLE.
- **Timeout path:** launch with no `hit`/`miss`.
  - After 20 FLIGHT cycles, `misses`=1; IDLE after 8 more cycles.
  - A second timeout gives `misses`=2, then OVER with `game_over`=1.
  - In OVER, a press clears the scores, gives IDLE and produces no `launch`.
- **Reset and saturation:**
  - Asserting `reset` mid-FLIGHT gives all outputs at reset values in the same cycle.
  - Ten consecutive hits leave `hits`=9.
